cd_local_xbar_nxm: RTL and testbench

CD_LOCAL_XBAR_NXM -- requirements
Module: cd_local_xbar_nxm

---
 rtl/cd_xbar_pkg.sv | 16 +
 rtl/rr_arb_n.sv | 43 ++++
 rtl/cd_local_xbar_nxm.sv | 152 +++++++++++++++
 tb/tb_cd_local_xbar_nxm.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_xbar_pkg.sv
// Shared defaults and helpers for the local converging crossbar.
// Imported by the arbiter and the crossbar top.
package cd_xbar_pkg;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_N_IN     = 4;
  localparam int DEF_N_CV     = 2;
  localparam int DEF_DEST_LSB = 0;
  localparam int DEF_DEST_W   = 3;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arb_n.sv
// Round-robin arbiter: grants only while en is high and
// moves its pointer to one past the winner on each grant.
module rr_arb_n
  import cd_xbar_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);
  localparam int PW = idx_w(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;
  int            idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int o = 0; o < N; o++) begin
      idx = (int'(ptr) + o) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign gnt = (en && found) ? (N'(1) << win) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end
endmodule

// File: rtl/cd_local_xbar_nxm.sv
// Local crossbar: converges N_IN router requests onto N_CV ports
// and steers N_CV reply streams back to routers by destination.
module cd_local_xbar_nxm
  import cd_xbar_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_IN     = DEF_N_IN,
  parameter int N_CV     = DEF_N_CV,
  parameter int DEST_LSB = DEF_DEST_LSB,
  parameter int DEST_W   = DEF_DEST_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN-1:0]          in_si,
  output logic [N_IN-1:0]          in_ri,
  input  logic [N_IN*DATA_W-1:0]   in_di,
  output logic [N_CV-1:0]          cv_so,
  input  logic [N_CV-1:0]          cv_ro,
  output logic [N_CV*DATA_W-1:0]   cv_do,
  input  logic [N_CV-1:0]          cv_si_r,
  output logic [N_CV-1:0]          cv_ri_r,
  input  logic [N_CV*DATA_W-1:0]   cv_di_r,
  output logic [N_IN-1:0]          out_so,
  input  logic [N_IN-1:0]          out_ro,
  output logic [N_IN*DATA_W-1:0]   out_do,
  output logic [DROP_W-1:0]        drop_cnt
);
  logic [N_IN-1:0] avail [N_CV+1];
  logic [N_IN-1:0] cgnt  [N_CV];
  logic [N_CV-1:0] cv_acc;

  assign avail[0] = in_si;
  assign cv_acc   = ~cv_so | cv_ro;

  // each arbiter only sees inputs left over by the ports before it
  for (genvar k = 0; k < N_CV; k++) begin : g_req
    logic [DATA_W-1:0] mux;
    logic              so_q;
    logic [DATA_W-1:0] do_q;

    rr_arb_n #(.N(N_IN)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (avail[k]),
      .en    (cv_acc[k]),
      .gnt   (cgnt[k])
    );

    assign avail[k+1] = avail[k] & ~cgnt[k];

    always_comb begin
      mux = '0;
      for (int i = 0; i < N_IN; i++)
        if (cgnt[k][i]) mux = mux | in_di[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        so_q <= 1'b0;
        do_q <= '0;
      end else if (|cgnt[k]) begin
        so_q <= 1'b1;
        do_q <= mux;
      end else if (cv_ro[k]) begin
        so_q <= 1'b0;
        do_q <= '0;
      end
    end

    assign cv_so[k] = so_q;
    assign cv_do[k*DATA_W +: DATA_W] = do_q;
  end

  assign in_ri = reset ? (in_si & ~avail[N_CV]) : '0;

  logic [DEST_W-1:0] dest [N_CV];
  logic [N_CV-1:0]   bad;
  logic [N_CV-1:0]   rgnt [N_IN];
  logic [N_IN-1:0]   out_acc;
  logic [N_CV-1:0]   taken;
  logic [8:0]        ndrop;
  logic [8:0]        drop_sum;

  for (genvar c = 0; c < N_CV; c++) begin : g_dst
    assign dest[c] = cv_di_r[c*DATA_W+DEST_LSB +: DEST_W];
    assign bad[c]  = cv_si_r[c] && (int'(dest[c]) >= N_IN);
  end

  assign out_acc = ~out_so | out_ro;

  for (genvar j = 0; j < N_IN; j++) begin : g_rep
    logic [N_CV-1:0]   rreq;
    logic [DATA_W-1:0] mux;
    logic              so_q;
    logic [DATA_W-1:0] do_q;

    always_comb begin
      rreq = '0;
      for (int c = 0; c < N_CV; c++)
        rreq[c] = cv_si_r[c] && (int'(dest[c]) == j);
    end

    rr_arb_n #(.N(N_CV)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (rreq),
      .en    (out_acc[j]),
      .gnt   (rgnt[j])
    );

    always_comb begin
      mux = '0;
      for (int c = 0; c < N_CV; c++)
        if (rgnt[j][c]) mux = mux | cv_di_r[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        so_q <= 1'b0;
        do_q <= '0;
      end else if (|rgnt[j]) begin
        so_q <= 1'b1;
        do_q <= mux;
      end else if (out_ro[j]) begin
        so_q <= 1'b0;
        do_q <= '0;
      end
    end

    assign out_so[j] = so_q;
    assign out_do[j*DATA_W +: DATA_W] = do_q;
  end

  // misrouted replies are swallowed so they never block the stream
  always_comb begin
    taken = bad;
    ndrop = '0;
    for (int j = 0; j < N_IN; j++) taken = taken | rgnt[j];
    for (int c = 0; c < N_CV; c++) ndrop = ndrop + 9'(bad[c]);
  end

  assign cv_ri_r  = reset ? taken : '0;
  assign drop_sum = {1'b0, drop_cnt} + ndrop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[8] ? DROP_MAX : drop_sum[7:0];
    end
  end
endmodule

// File: tb/tb_cd_local_xbar_nxm.sv
// Self-checking bench for cd_local_xbar_nxm: vector table, corner
// sequences and random traffic against a cycle-level reference model.
module tb_cd_local_xbar_nxm;
  localparam int DW = 64;
  localparam int NI = 4;
  localparam int NC = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NI-1:0]   in_si = '0;
  logic [NI-1:0]   in_ri;
  logic [NI*DW-1:0] in_di = '0;
  logic [NC-1:0]   cv_so;
  logic [NC-1:0]   cv_ro = '0;
  logic [NC*DW-1:0] cv_do;
  logic [NC-1:0]   cv_si_r = '0;
  logic [NC-1:0]   cv_ri_r;
  logic [NC*DW-1:0] cv_di_r = '0;
  logic [NI-1:0]   out_so;
  logic [NI-1:0]   out_ro = '0;
  logic [NI*DW-1:0] out_do;
  logic [7:0]      drop_cnt;

  always #5 clk = ~clk;

  cd_local_xbar_nxm dut (
    .clk(clk), .reset(reset),
    .in_si(in_si), .in_ri(in_ri), .in_di(in_di),
    .cv_so(cv_so), .cv_ro(cv_ro), .cv_do(cv_do),
    .cv_si_r(cv_si_r), .cv_ri_r(cv_ri_r), .cv_di_r(cv_di_r),
    .out_so(out_so), .out_ro(out_ro), .out_do(out_do),
    .drop_cnt(drop_cnt)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // reference state: what each output register holds, pointers
  bit             mcv_v [NC];
  logic [DW-1:0]  mcv_d [NC];
  int             mptr  [NC];
  bit             mo_v  [NI];
  logic [DW-1:0]  mo_d  [NI];
  int             mrptr [NI];
  int             mdrop;

  // DUT values observed mid-cycle by the last step
  logic [NI-1:0]    s_in_ri;
  logic [NC-1:0]    s_cv_ri_r;
  logic [NC-1:0]    s_cv_so;
  logic [NI-1:0]    s_out_so;
  logic [NI*DW-1:0] s_out_do;
  logic [7:0]       s_drop;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h",
                  nm, $time, act, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NC; k++) begin
      mcv_v[k] = 0; mcv_d[k] = '0; mptr[k] = 0;
    end
    for (int j = 0; j < NI; j++) begin
      mo_v[j] = 0; mo_d[j] = '0; mrptr[j] = 0;
    end
    mdrop = 0;
  endfunction

  function automatic logic [DW-1:0] mk(input int d);
    logic [DW-1:0] v;
    v = {$urandom, $urandom};
    v[2:0] = 3'(d);
    return v;
  endfunction

  task automatic step(input logic [NI-1:0] si, input logic [NC-1:0] cro,
                      input logic [NC-1:0] rsi, input logic [NI-1:0] oro,
                      input logic [NI*DW-1:0] di,
                      input logic [NC*DW-1:0] rdi);
    logic [NI-1:0]    e_ri;
    logic [NC-1:0]    e_rri;
    logic [NC-1:0]    e_cvso;
    logic [NC*DW-1:0] e_cvdo;
    logic [NI-1:0]    e_oso;
    logic [NI*DW-1:0] e_odo;
    int               e_drop, w, i, c, nd;
    int               dst [NC];
    in_si = si; cv_ro = cro; in_di = di;
    cv_si_r = rsi; out_ro = oro; cv_di_r = rdi;
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      e_cvso[k] = mcv_v[k];
      e_cvdo[k*DW +: DW] = mcv_v[k] ? mcv_d[k] : '0;
    end
    for (int j = 0; j < NI; j++) begin
      e_oso[j] = mo_v[j];
      e_odo[j*DW +: DW] = mo_v[j] ? mo_d[j] : '0;
    end
    e_drop = mdrop;
    e_ri = '0;
    for (int k = 0; k < NC; k++) begin
      if (!mcv_v[k] || cro[k]) begin
        w = -1;
        for (int o = 0; o < NI; o++) begin
          i = (mptr[k] + o) % NI;
          if (w < 0 && si[i] && !e_ri[i]) w = i;
        end
        if (w >= 0) begin
          e_ri[w] = 1'b1;
          mcv_v[k] = 1;
          mcv_d[k] = di[w*DW +: DW];
          mptr[k] = (w + 1) % NI;
        end else if (cro[k]) mcv_v[k] = 0;
      end
    end
    e_rri = '0;
    nd = 0;
    for (int k = 0; k < NC; k++) begin
      dst[k] = int'(rdi[k*DW +: 3]);
      if (rsi[k] && dst[k] >= NI) begin
        e_rri[k] = 1'b1;
        nd++;
      end
    end
    for (int j = 0; j < NI; j++) begin
      if (!mo_v[j] || oro[j]) begin
        w = -1;
        for (int o = 0; o < NC; o++) begin
          c = (mrptr[j] + o) % NC;
          if (w < 0 && rsi[c] && dst[c] == j) w = c;
        end
        if (w >= 0) begin
          e_rri[w] = 1'b1;
          mo_v[j] = 1;
          mo_d[j] = rdi[w*DW +: DW];
          mrptr[j] = (w + 1) % NC;
        end else if (oro[j]) mo_v[j] = 0;
      end
    end
    mdrop = (mdrop + nd > 255) ? 255 : mdrop + nd;
    chk("in_ri", 256'(in_ri), 256'(e_ri));
    chk("cv_ri_r", 256'(cv_ri_r), 256'(e_rri));
    chk("cv_so", 256'(cv_so), 256'(e_cvso));
    chk("cv_do", 256'(cv_do), 256'(e_cvdo));
    chk("out_so", 256'(out_so), 256'(e_oso));
    chk("out_do", 256'(out_do), 256'(e_odo));
    chk("drop_cnt", 256'(drop_cnt), 256'(e_drop));
    s_in_ri = in_ri; s_cv_ri_r = cv_ri_r; s_cv_so = cv_so;
    s_out_so = out_so; s_out_do = out_do; s_drop = drop_cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_si = '0; cv_si_r = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [NI*DW-1:0] rnd_di();
    logic [NI*DW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*DW +: DW] = {$urandom, $urandom};
    return v;
  endfunction

  typedef struct {
    logic [NI-1:0] si;
    logic [NC-1:0] cro;
    logic [NI-1:0] e_ri;
    logic [NC-1:0] e_so;
  } vec_t;

  vec_t tbl [12];

  logic [DW-1:0] fa, fb;
  int            okc;

  initial begin
    tbl[0]  = '{4'b1111, 2'b11, 4'b0011, 2'b00};
    tbl[1]  = '{4'b1111, 2'b11, 4'b0110, 2'b11};
    tbl[2]  = '{4'b1111, 2'b11, 4'b1100, 2'b11};
    tbl[3]  = '{4'b1111, 2'b11, 4'b1001, 2'b11};
    tbl[4]  = '{4'b0000, 2'b11, 4'b0000, 2'b11};
    tbl[5]  = '{4'b1111, 2'b01, 4'b0011, 2'b00};
    tbl[6]  = '{4'b1111, 2'b01, 4'b0010, 2'b11};
    tbl[7]  = '{4'b1111, 2'b01, 4'b0100, 2'b11};
    tbl[8]  = '{4'b1111, 2'b01, 4'b1000, 2'b11};
    tbl[9]  = '{4'b1111, 2'b01, 4'b0001, 2'b11};
    tbl[10] = '{4'b0000, 2'b11, 4'b0000, 2'b11};
    tbl[11] = '{4'b0000, 2'b00, 4'b0000, 2'b00};

    model_reset();
    #2;
    chk("rst_cv_so", 256'(cv_so), 256'(0));
    chk("rst_out_do", 256'(out_do), 256'(0));
    do_reset();

    for (int n = 0; n < 12; n++) begin
      step(tbl[n].si, tbl[n].cro, '0, 4'hF, rnd_di(), '0);
      chk($sformatf("tbl%0d_in_ri", n), 256'(s_in_ri), 256'(tbl[n].e_ri));
      chk($sformatf("tbl%0d_cv_so", n), 256'(s_cv_so), 256'(tbl[n].e_so));
    end

    // two replies to the same router: round robin over two cycles
    do_reset();
    fa = mk(2); fb = mk(2);
    step('0, 2'b11, 2'b11, 4'hF, '0, {fb, fa});
    chk("same_dst_c0", 256'(s_cv_ri_r), 256'(2'b01));
    step('0, 2'b11, 2'b10, 4'hF, '0, {fb, fa});
    chk("same_dst_c1", 256'(s_cv_ri_r), 256'(2'b10));
    chk("same_dst_so1", 256'(s_out_so), 256'(4'b0100));
    step('0, 2'b11, 2'b00, 4'hF, '0, '0);
    chk("same_dst_so2", 256'(s_out_so), 256'(4'b0100));
    chk("same_dst_d2", 256'(s_out_do[2*DW +: DW]), 256'(fb));
    step('0, 2'b11, 2'b00, 4'hF, '0, '0);
    chk("same_dst_idle", 256'(s_out_do), 256'(0));

    // stalled reply port holds data and back-pressures the source
    fa = mk(1); fb = mk(1);
    step('0, 2'b11, 2'b01, 4'hF, '0, {64'd0, fa});
    chk("stall_load", 256'(s_cv_ri_r), 256'(2'b01));
    for (int n = 0; n < 3; n++) begin
      step('0, 2'b11, 2'b01, 4'b1101, '0, {64'd0, fb});
      chk("stall_ri", 256'(s_cv_ri_r), 256'(2'b00));
      chk("stall_do", 256'(s_out_do[DW +: DW]), 256'(fa));
    end
    step('0, 2'b11, 2'b01, 4'hF, '0, {64'd0, fb});
    chk("stall_release", 256'(s_cv_ri_r), 256'(2'b01));
    step('0, 2'b11, 2'b00, 4'hF, '0, '0);
    chk("stall_next", 256'(s_out_do[DW +: DW]), 256'(fb));

    // invalid destinations: double drop, then saturation
    do_reset();
    step('0, 2'b11, 2'b11, 4'hF, '0, {mk(7), mk(4)});
    step('0, 2'b11, 2'b00, 4'hF, '0, '0);
    chk("drop_two", 256'(s_drop), 256'(2));
    okc = 0;
    for (int n = 0; n < 300; n++) begin
      step('0, 2'b11, 2'b01, 4'hF, '0, {64'd0, mk(5)});
      if (s_cv_ri_r == 2'b01 && s_out_so == '0) okc++;
    end
    chk("drop_all_cycles", 256'(okc), 256'(300));
    step('0, 2'b11, 2'b00, 4'hF, '0, '0);
    chk("drop_sat", 256'(s_drop), 256'(255));

    // asynchronous reset with every register full
    step(4'hF, 2'b00, 2'b11, 4'h0, rnd_di(), {mk(3), mk(0)});
    step(4'hF, 2'b00, 2'b11, 4'h0, rnd_di(), {mk(3), mk(0)});
    reset = 1'b0;
    #1;
    chk("arst_cv_so", 256'(cv_so), 256'(0));
    chk("arst_out_so", 256'(out_so), 256'(0));
    chk("arst_in_ri", 256'(in_ri), 256'(0));
    chk("arst_cv_ri_r", 256'(cv_ri_r), 256'(0));
    chk("arst_cv_do", 256'(cv_do), 256'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(4'hF, 2'b11, 2'b00, 4'hF, rnd_di(), '0);
    chk("arst_first_gnt", 256'(s_in_ri), 256'(4'b0011));

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [NC*DW-1:0] rdi;
      int d;
      for (int k = 0; k < NC; k++) begin
        d = ($urandom_range(9) < 8) ? $urandom_range(3)
                                    : $urandom_range(7, 4);
        rdi[k*DW +: DW] = mk(d);
      end
      step(NI'($urandom), NC'($urandom), NC'($urandom),
           NI'($urandom | $urandom), rnd_di(), rdi);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
